branch_recovery_ctrl: RTL and testbench

Sequences recovery from branch mispredictions. It sits between the branch unit, the ROB and the fetch/scheduler front end. It captures the oldest outstanding mispredicted branch reported by the branch unit and waits until that branch commits at the ROB head. It then asserts a flush of speculative state for a fixed number of cycles and hands the corrected fetch address to fetch through a valid/ready handshake.

---
 rtl/branch_recovery_ctrl.sv | 104 ++++++++++
 tb/tb_branch_recovery_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_recovery_ctrl.sv
// Branch misprediction recovery sequencer: holds the oldest mispredicted branch,
// waits for it to commit, flushes speculative state, then redirects fetch.
module branch_recovery_ctrl #(
   parameter int unsigned ADDR_W       = 10,
   parameter int unsigned ROB_ID_W     = 4,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                miss_valid,
   input  logic [ROB_ID_W-1:0] miss_rob_id,
   input  logic [ADDR_W-1:0]   miss_dst,
   input  logic [ROB_ID_W-1:0] rob_head_id,
   input  logic                commit_valid,
   input  logic [ROB_ID_W-1:0] commit_rob_id,
   output logic                flush,
   output logic                stall_issue,
   output logic                redirect_valid,
   output logic [ADDR_W-1:0]   redirect_pc,
   input  logic                redirect_ready,
   output logic                busy
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_FLUSH,
      ST_REDIRECT
   } state_t;

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

   state_t              state_q, state_d;
   logic [ROB_ID_W-1:0] held_id_q, held_id_d;
   logic [ADDR_W-1:0]   held_dst_q, held_dst_d;
   logic [3:0]          flush_cnt_q, flush_cnt_d;

   // Ages are distances from the ROB head, so wraparound of tags is handled naturally.
   logic [ROB_ID_W-1:0] miss_age, held_age;
   assign miss_age = miss_rob_id - rob_head_id;
   assign held_age = held_id_q - rob_head_id;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         held_id_q   <= '0;
         held_dst_q  <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         held_id_q   <= held_id_d;
         held_dst_q  <= held_dst_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      held_id_d   = held_id_q;
      held_dst_d  = held_dst_q;
      flush_cnt_d = flush_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (miss_valid) begin
               held_id_d  = miss_rob_id;
               held_dst_d = miss_dst;
               if (commit_valid && commit_rob_id == miss_rob_id) begin
                  state_d     = ST_FLUSH;
                  flush_cnt_d = FLUSH_LOAD;
               end else begin
                  state_d = ST_ARMED;
               end
            end
         end
         ST_ARMED: begin
            // A commit of the held branch takes priority over any concurrent miss.
            if (commit_valid && commit_rob_id == held_id_q) begin
               state_d     = ST_FLUSH;
               flush_cnt_d = FLUSH_LOAD;
            end else if (miss_valid && miss_age < held_age) begin
               held_id_d  = miss_rob_id;
               held_dst_d = miss_dst;
            end
         end
         ST_FLUSH: begin
            if (flush_cnt_q == 4'd0) state_d = ST_REDIRECT;
            else                     flush_cnt_d = flush_cnt_q - 4'd1;
         end
         ST_REDIRECT: begin
            if (redirect_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      flush          = (state_q == ST_FLUSH);
      stall_issue    = (state_q == ST_FLUSH) || (state_q == ST_REDIRECT);
      redirect_valid = (state_q == ST_REDIRECT);
      redirect_pc    = (state_q == ST_REDIRECT) ? held_dst_q : '0;
      busy           = (state_q != ST_IDLE);
   end

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// Directed-vector bench for branch_recovery_ctrl with hand-computed expectations.
module tb_branch_recovery_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       miss_valid;
   logic [3:0] miss_rob_id;
   logic [9:0] miss_dst;
   logic [3:0] rob_head_id;
   logic       commit_valid;
   logic [3:0] commit_rob_id;
   logic       flush;
   logic       stall_issue;
   logic       redirect_valid;
   logic [9:0] redirect_pc;
   logic       redirect_ready;
   logic       busy;

   int vectors    = 0;
   int miscompares = 0;

   branch_recovery_ctrl #(
      .ADDR_W      (10),
      .ROB_ID_W    (4),
      .FLUSH_CYCLES(2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .miss_valid    (miss_valid),
      .miss_rob_id   (miss_rob_id),
      .miss_dst      (miss_dst),
      .rob_head_id   (rob_head_id),
      .commit_valid  (commit_valid),
      .commit_rob_id (commit_rob_id),
      .flush         (flush),
      .stall_issue   (stall_issue),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .redirect_ready(redirect_ready),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic f, input logic s, input logic rv,
                             input logic [9:0] pc, input logic b);
      check({tag, ".flush"},          32'(flush),          32'(f));
      check({tag, ".stall_issue"},    32'(stall_issue),    32'(s));
      check({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(rv));
      check({tag, ".redirect_pc"},    32'(redirect_pc),    32'(pc));
      check({tag, ".busy"},           32'(busy),           32'(b));
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic miss(input logic [3:0] id, input logic [9:0] dst);
      miss_valid  = 1'b1;
      miss_rob_id = id;
      miss_dst    = dst;
   endtask

   task automatic commit(input logic [3:0] id);
      commit_valid  = 1'b1;
      commit_rob_id = id;
   endtask

   task automatic idle_inputs;
      miss_valid    = 1'b0;
      commit_valid  = 1'b0;
      miss_rob_id   = '0;
      miss_dst      = '0;
      commit_rob_id = '0;
   endtask

   initial begin
      rst            = 1'b1;
      rob_head_id    = '0;
      redirect_ready = 1'b1;
      idle_inputs();
      tick();
      tick();
      check_outs("reset", 0, 0, 0, 10'h000, 0);
      rst = 1'b0;
      tick();
      check_outs("post_reset", 0, 0, 0, 10'h000, 0);

      // basic recovery, FLUSH_CYCLES=2
      miss(4'd3, 10'h123);
      tick();
      idle_inputs();
      check_outs("t1_armed", 0, 0, 0, 10'h000, 1);
      tick();
      tick();
      commit(4'd3);
      tick();
      idle_inputs();
      check_outs("t1_flush1", 1, 1, 0, 10'h000, 1);
      miss(4'd0, 10'h3FF);  // ignored during flush
      tick();
      idle_inputs();
      check_outs("t1_flush2", 1, 1, 0, 10'h000, 1);
      tick();
      check_outs("t1_redirect", 0, 1, 1, 10'h123, 1);
      tick();
      check_outs("t1_idle", 0, 0, 0, 10'h000, 0);

      // wraparound age: head=14, tag 15 older than tag 1
      rob_head_id = 4'd14;
      miss(4'd1, 10'h010);
      tick();
      miss(4'd15, 10'h0F0);
      tick();
      idle_inputs();
      commit(4'd1);
      tick();
      idle_inputs();
      check_outs("t2_stale_commit", 0, 0, 0, 10'h000, 1);
      commit(4'd15);
      tick();
      idle_inputs();
      check_outs("t2_flush1", 1, 1, 0, 10'h000, 1);
      tick();
      tick();
      check_outs("t2_redirect", 0, 1, 1, 10'h0F0, 1);
      tick();
      check_outs("t2_idle", 0, 0, 0, 10'h000, 0);

      // equal/younger misses dropped; commit beats a simultaneous older miss
      rob_head_id = 4'd2;
      miss(4'd5, 10'h055);
      tick();
      miss(4'd5, 10'h3AA);
      tick();
      miss(4'd9, 10'h199);
      tick();
      idle_inputs();
      commit(4'd5);
      miss(4'd3, 10'h333);
      tick();
      idle_inputs();
      check_outs("t3_flush1", 1, 1, 0, 10'h000, 1);
      tick();
      tick();
      check_outs("t3_redirect", 0, 1, 1, 10'h055, 1);
      tick();
      check_outs("t3_idle", 0, 0, 0, 10'h000, 0);

      // back-pressure from fetch
      rob_head_id    = 4'd0;
      redirect_ready = 1'b0;
      miss(4'd2, 10'h2A2);
      tick();
      idle_inputs();
      commit(4'd2);
      tick();
      idle_inputs();
      tick();
      tick();
      for (int i = 0; i < 4; i++) begin
         check_outs($sformatf("t4_hold%0d", i), 0, 1, 1, 10'h2A2, 1);
         tick();
      end
      check_outs("t4_hold4", 0, 1, 1, 10'h2A2, 1);
      redirect_ready = 1'b1;
      tick();
      check_outs("t4_idle", 0, 0, 0, 10'h000, 0);

      // same-cycle miss and commit from IDLE skips ARMED
      miss(4'd7, 10'h077);
      commit(4'd7);
      tick();
      idle_inputs();
      check_outs("t5_flush1", 1, 1, 0, 10'h000, 1);
      tick();
      check_outs("t5_flush2", 1, 1, 0, 10'h000, 1);
      tick();
      check_outs("t5_redirect", 0, 1, 1, 10'h077, 1);
      tick();
      check_outs("t5_idle", 0, 0, 0, 10'h000, 0);

      // reset mid-flush abandons recovery
      miss(4'd4, 10'h0AB);
      tick();
      idle_inputs();
      commit(4'd4);
      tick();
      idle_inputs();
      check_outs("t6_flush1", 1, 1, 0, 10'h000, 1);
      tick();
      check_outs("t6_flush2", 1, 1, 0, 10'h000, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_outs("t6_reset", 0, 0, 0, 10'h000, 0);
      commit(4'd4);
      tick();
      idle_inputs();
      check_outs("t6_old_commit", 0, 0, 0, 10'h000, 0);
      tick();
      check_outs("t6_quiet", 0, 0, 0, 10'h000, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
